// File: rtl/elem_cmd_sched.sv
// Timed command scheduler for one signal-generation element: buffers commands
// in a small FIFO and releases each one as a one-cycle cmdstb at its trigger time.
module elem_cmd_sched #(
  parameter int DEPTH          = 4,
  parameter int TCNTWIDTH      = 32,
  parameter int ENV_ADDRWIDTH  = 12,
  parameter int FREQ_ADDRWIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [TCNTWIDTH-1:0]      tcnt,
  input  logic                      run,
  input  logic                      flush,
  input  logic                      clr_err,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [TCNTWIDTH-1:0]      in_trig,
  input  logic [ENV_ADDRWIDTH-1:0]  in_envstart,
  input  logic [ENV_ADDRWIDTH-1:0]  in_envlength,
  input  logic [FREQ_ADDRWIDTH-1:0] in_freqaddr,
  input  logic [16:0]               in_pini,
  input  logic [15:0]               in_ampx,
  input  logic [15:0]               in_ampy,
  input  logic                      elem_valid,
  output logic                      cmdstb,
  output logic [ENV_ADDRWIDTH-1:0]  envstart,
  output logic [ENV_ADDRWIDTH-1:0]  envlength,
  output logic [FREQ_ADDRWIDTH-1:0] freqaddr,
  output logic [16:0]               pini,
  output logic [15:0]               ampx,
  output logic [15:0]               ampy,
  output logic [LW-1:0]             level,
  output logic                      late_err,
  output logic                      overlap_err
);

  localparam int FW = 2*ENV_ADDRWIDTH + FREQ_ADDRWIDTH + 17 + 32;
  localparam int W  = TCNTWIDTH + FW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_FIRE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_nxt;
  logic [W-1:0]         r_mem [DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [LW-1:0]        r_level;
  logic [FW-1:0]        r_fields;
  logic                 r_late_err;
  logic                 r_overlap_err;

  logic [W-1:0]         w_in_word;
  logic [W-1:0]         w_head;
  logic [TCNTWIDTH-1:0] w_head_trig;
  logic [TCNTWIDTH-1:0] w_d;
  logic                 w_d_neg;
  logic                 w_d_zero;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_set_late;
  logic                 w_set_overlap;

  assign w_in_word   = {in_trig, in_envstart, in_envlength, in_freqaddr,
                        in_pini, in_ampx, in_ampy};
  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_trig = w_head[W-1 -: TCNTWIDTH];

  // Modular difference; its sign bit tells early vs. past-due across tcnt wrap.
  assign w_d      = tcnt - w_head_trig;
  assign w_d_neg  = w_d[TCNTWIDTH-1];
  assign w_d_zero = (w_d == '0);

  assign in_ready = (r_level < LW'(DEPTH));
  assign w_push   = in_valid && in_ready && !flush;

  always_comb begin
    w_nxt      = r_state;
    w_pop      = 1'b0;
    w_set_late = 1'b0;
    case (r_state)
      S_IDLE: if (r_level != '0) w_nxt = S_WAIT;
      S_WAIT: begin
        if (run && !w_d_neg) begin
          w_nxt      = S_FIRE;
          w_pop      = 1'b1;
          w_set_late = !w_d_zero;
        end
      end
      S_FIRE:  w_nxt = (r_level != '0) ? S_WAIT : S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
    if (flush) begin
      w_nxt      = S_IDLE;
      w_pop      = 1'b0;
      w_set_late = 1'b0;
    end
  end

  assign w_set_overlap = (r_state == S_FIRE) && elem_valid;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_in_word;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_level       <= '0;
      r_fields      <= '0;
      r_late_err    <= 1'b0;
      r_overlap_err <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        r_level <= r_level + LW'(w_push) - LW'(w_pop);
      end
      if (w_pop) r_fields <= w_head[FW-1:0];
      // A set event in the same cycle as clr_err keeps the flag set.
      r_late_err    <= (r_late_err    && !clr_err) || w_set_late;
      r_overlap_err <= (r_overlap_err && !clr_err) || w_set_overlap;
    end
  end

  assign cmdstb = (r_state == S_FIRE);
  assign {envstart, envlength, freqaddr, pini, ampx, ampy} = r_fields;
  assign level       = r_level;
  assign late_err    = r_late_err;
  assign overlap_err = r_overlap_err;

endmodule

// File: tb/tb_elem_cmd_sched.sv
// Scoreboard bench for elem_cmd_sched: expected strobes are queued at push time
// and matched against every cmdstb seen by the negedge monitor.
module tb_elem_cmd_sched;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] tcnt;
  logic        run, flush, clr_err, in_valid, elem_valid;
  logic        in_ready;
  logic [31:0] in_trig;
  logic [11:0] in_envstart, in_envlength;
  logic [7:0]  in_freqaddr;
  logic [16:0] in_pini;
  logic [15:0] in_ampx, in_ampy;
  logic        cmdstb;
  logic [11:0] envstart, envlength;
  logic [7:0]  freqaddr;
  logic [16:0] pini;
  logic [15:0] ampx, ampy;
  logic [2:0]  level;
  logic        late_err, overlap_err;

  elem_cmd_sched dut (
    .clk(clk), .resetn(resetn), .tcnt(tcnt), .run(run), .flush(flush),
    .clr_err(clr_err), .in_valid(in_valid), .in_ready(in_ready),
    .in_trig(in_trig), .in_envstart(in_envstart), .in_envlength(in_envlength),
    .in_freqaddr(in_freqaddr), .in_pini(in_pini), .in_ampx(in_ampx),
    .in_ampy(in_ampy), .elem_valid(elem_valid), .cmdstb(cmdstb),
    .envstart(envstart), .envlength(envlength), .freqaddr(freqaddr),
    .pini(pini), .ampx(ampx), .ampy(ampy), .level(level),
    .late_err(late_err), .overlap_err(overlap_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic [11:0] envstart;
    logic [11:0] envlength;
    logic [7:0]  freqaddr;
    logic [16:0] pini;
    logic [15:0] ampx;
    logic [15:0] ampy;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_fire;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b1;
  bit   got_stb;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (tcnt=%0d)", tag, got, exp, tcnt);
    end
  endtask

  // tcnt advances by one per clock, shortly after each rising edge
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      tcnt = tcnt + 32'd1;
    end
  endtask

  task automatic tick_to(input logic [31:0] t);
    int guard = 0;
    while (tcnt != t && guard < 2000) begin
      tick();
      guard++;
    end
    if (tcnt != t) check("tick_to_timeout", 0, 1);
  endtask

  task automatic push_cmd(input logic [31:0] trig, input logic [11:0] es,
                          input logic [11:0] el, input logic [31:0] lo,
                          input logic [31:0] hi, input bit accept, input bit track);
    exp_t e;
    in_valid     = 1'b1;
    in_trig      = trig;
    in_envstart  = es;
    in_envlength = el;
    in_freqaddr  = 8'($urandom);
    in_pini      = 17'($urandom);
    in_ampx      = 16'($urandom);
    in_ampy      = 16'($urandom);
    check("in_ready_before_push", 64'(in_ready), 64'(accept));
    if (accept && track) begin
      e.lo = lo; e.hi = hi; e.envstart = es; e.envlength = el;
      e.freqaddr = in_freqaddr; e.pini = in_pini; e.ampx = in_ampx; e.ampy = in_ampy;
      sb_q.push_back(e);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_timeout", 64'(sb_q.size()), 0);
    tick(2);
  endtask

  always @(negedge clk) begin
    if (mon_en && resetn === 1'b1 && cmdstb === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("spurious_cmdstb", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        last_fire = e;
        check("fire_time_in_window", 64'((tcnt - e.lo) <= (e.hi - e.lo)), 1);
        check("envstart", 64'(envstart), 64'(e.envstart));
        check("envlength", 64'(envlength), 64'(e.envlength));
        check("freqaddr", 64'(freqaddr), 64'(e.freqaddr));
        check("pini", 64'(pini), 64'(e.pini));
        check("ampxy", 64'({ampx, ampy}), 64'({e.ampx, e.ampy}));
      end
    end
  end

  initial begin
    resetn = 1'b0; tcnt = 32'd0; run = 1'b0; flush = 1'b0; clr_err = 1'b0;
    in_valid = 1'b0; elem_valid = 1'b0; in_trig = '0; in_envstart = '0;
    in_envlength = '0; in_freqaddr = '0; in_pini = '0; in_ampx = '0; in_ampy = '0;
    #23;
    check("rst_level", 64'(level), 0);
    check("rst_in_ready", 64'(in_ready), 1);
    check("rst_cmdstb", 64'(cmdstb), 0);
    check("rst_fields", 64'({envstart, envlength, freqaddr, pini, ampx, ampy}), 0);
    check("rst_errs", 64'({late_err, overlap_err}), 0);
    resetn = 1'b1;
    run    = 1'b1;
    tick(2);

    // on-time single command
    tick_to(32'd90);
    push_cmd(32'd100, 12'h010, 12'h020, 32'd101, 32'd101, 1'b1, 1'b1);
    check("t1_level_after_push", 64'(level), 1);
    tick_to(32'd111);
    check("t1_drained", 64'(sb_q.size()), 0);
    check("t1_level_end", 64'(level), 0);
    check("t1_envstart_held", 64'(envstart), 12'h010);
    check("t1_envlength_held", 64'(envlength), 12'h020);
    check("t1_errs", 64'({late_err, overlap_err}), 0);

    // fill to DEPTH, fifth write refused
    tick_to(32'd150);
    for (int i = 0; i < 4; i++)
      push_cmd(32'd200 + 32'(10*i), 12'(i + 1), 12'(i + 5),
               32'd201 + 32'(10*i), 32'd201 + 32'(10*i), 1'b1, 1'b1);
    check("t2_level_full", 64'(level), 4);
    check("t2_not_ready", 64'(in_ready), 0);
    push_cmd(32'd205, 12'hBAD, 12'hBAD, 0, 0, 1'b0, 1'b0);
    check("t2_level_after_refused", 64'(level), 4);
    wait_drain(200);
    check("t2_errs", 64'({late_err, overlap_err}), 0);

    // late trigger, then clr_err
    tcnt = 32'd80;
    push_cmd(32'd50, 12'h055, 12'h066, 32'd81, 32'd83, 1'b1, 1'b1);
    wait_drain(10);
    check("t3_late_set", 64'(late_err), 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("t3_late_cleared", 64'(late_err), 0);

    // trigger across tcnt wrap
    tcnt = 32'hFFFF_FFF0;
    push_cmd(32'h0000_0005, 12'h0A5, 12'h05A, 32'd6, 32'd6, 1'b1, 1'b1);
    wait_drain(40);
    check("t4_no_late_on_wrap", 64'(late_err), 0);

    // overlap with element busy, consecutive trig fires one cycle late
    tcnt = 32'd280;
    elem_valid = 1'b1;
    push_cmd(32'd300, 12'h300, 12'h030, 32'd301, 32'd301, 1'b1, 1'b1);
    push_cmd(32'd301, 12'h301, 12'h031, 32'd303, 32'd303, 1'b1, 1'b1);
    wait_drain(40);
    check("t5_overlap_set", 64'(overlap_err), 1);
    check("t5_late_set", 64'(late_err), 1);
    elem_valid = 1'b0;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("t5_errs_cleared", 64'({late_err, overlap_err}), 0);

    // run low past all triggers, then flush with a concurrent write
    run = 1'b0;
    tcnt = 32'd305;
    for (int i = 0; i < 3; i++)
      push_cmd(32'd310 + 32'(i), 12'hEEE, 12'hEEE, 0, 0, 1'b1, 1'b0);
    tick_to(32'd330);
    check("t6_level_frozen", 64'(level), 3);
    flush = 1'b1;
    in_valid = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("t6_level_flushed", 64'(level), 0);
    check("t6_cmdstb_low", 64'(cmdstb), 0);
    check("t6_fields_unchanged", 64'({envstart, envlength}),
          64'({last_fire.envstart, last_fire.envlength}));
    run = 1'b1;
    tick(5);
    check("t6_level_still_zero", 64'(level), 0);
    check("t6_errs_unchanged", 64'({late_err, overlap_err}), 0);

    // async reset in the FIRE cycle
    mon_en = 1'b0;
    push_cmd(tcnt + 32'd4, 12'h777, 12'h111, 0, 0, 1'b1, 1'b0);
    got_stb = 1'b0;
    for (int i = 0; i < 20 && !got_stb; i++) begin
      if (cmdstb === 1'b1) got_stb = 1'b1;
      else tick();
    end
    check("t7_fire_seen", 64'(got_stb), 1);
    #2;
    resetn = 1'b0;
    #1;
    check("t7_cmdstb_async_low", 64'(cmdstb), 0);
    check("t7_fields_reset", 64'(envstart), 0);
    #3;
    resetn = 1'b1;
    tick(2);

    check("sb_empty_at_end", 64'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
